// File: rtl/stim_seq_ctrl.sv
// Stimulus sequencer: drives a latched bit pattern into a DUT one element per cycle
// and scores the DUT response, LAT cycles later, against a latched expected pattern.
// The expected-bits port is called "expected" because "expect" is a reserved word.
module stim_seq_ctrl #(
    parameter int MAXLEN = 16,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        len,
    input  logic [MAXLEN-1:0] pattern,
    input  logic [MAXLEN-1:0] expected,
    output logic              dut_a,
    input  logic              dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [4:0]        err_cnt,
    output logic [3:0]        first_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_e;

    localparam int         MAX_CAP = (MAXLEN > 31) ? 31 : MAXLEN;
    localparam logic [4:0] MAX5    = 5'(MAX_CAP);
    localparam logic [1:0] LAT_M1  = (LAT == 0) ? 2'd0 : 2'(LAT - 1);
    localparam int         SEL     = (LAT == 0) ? 0 : LAT - 1;

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [4:0]        eff_len_q, eff_len_d;
    logic [1:0]        drain_q, drain_d;
    logic [MAXLEN-1:0] pattern_q, pattern_d;
    logic [MAXLEN-1:0] expect_q, expect_d;
    logic              dut_a_q, dut_a_d;
    logic              pass_q, pass_d;
    logic [4:0]        err_cnt_q, err_cnt_d;
    logic [3:0]        first_err_q, first_err_d;
    logic [2:0]        pv_q, pv_d;
    logic [2:0][4:0]   pidx_q, pidx_d;

    logic              run_busy;
    logic              issue;
    logic              flush;
    logic              cmp_v;
    logic [4:0]        cmp_idx;
    logic              mismatch;
    logic [4:0]        eff_len_in;
    logic [4:0]        next_idx;
    logic [MAXLEN-1:0] pat_shift;
    logic [MAXLEN-1:0] exp_shift;

    assign run_busy = (state_q == DRIVE) || (state_q == DRAIN);
    assign issue    = (state_q == DRIVE);
    assign flush    = run_busy && abort;
    assign next_idx = idx_q + 5'd1;
    assign eff_len_in = (len > MAX5) ? MAX5 : len;

    // Compare point: element issued in DRIVE is scored LAT cycles later.
    always_comb begin
        if (LAT == 0) begin
            cmp_v   = issue;
            cmp_idx = idx_q;
        end else begin
            cmp_v   = pv_q[SEL];
            cmp_idx = pidx_q[SEL];
        end
        exp_shift = expect_q >> cmp_idx;
        mismatch  = cmp_v && run_busy && (dut_out != exp_shift[0]);
    end

    always_comb begin
        pv_d   = {pv_q[1:0], issue};
        pidx_d = {pidx_q[1:0], idx_q};
        if (flush) begin
            pv_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        eff_len_d   = eff_len_q;
        drain_d     = drain_q;
        pattern_d   = pattern_q;
        expect_d    = expect_q;
        dut_a_d     = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pat_shift   = pattern_q >> next_idx;

        if (mismatch) begin
            if (err_cnt_q != 5'd31) begin
                err_cnt_d = err_cnt_q + 5'd1;
            end
            pass_d = 1'b0;
            if (pass_q) begin
                first_err_d = cmp_idx[3:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    pattern_d   = pattern;
                    expect_d    = expected;
                    eff_len_d   = eff_len_in;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    pass_d      = 1'b1;
                    idx_d       = '0;
                    if (eff_len_in == 5'd0) begin
                        state_d = FIN;
                    end else begin
                        state_d = DRIVE;
                        dut_a_d = pattern[0];
                    end
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q == eff_len_q - 5'd1) begin
                    drain_d = '0;
                    state_d = (LAT == 0) ? FIN : DRAIN;
                end else begin
                    idx_d   = next_idx;
                    dut_a_d = pat_shift[0];
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (drain_q == LAT_M1) begin
                    state_d = FIN;
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            eff_len_q   <= '0;
            drain_q     <= '0;
            pattern_q   <= '0;
            expect_q    <= '0;
            dut_a_q     <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pv_q        <= '0;
            pidx_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            eff_len_q   <= eff_len_d;
            drain_q     <= drain_d;
            pattern_q   <= pattern_d;
            expect_q    <= expect_d;
            dut_a_q     <= dut_a_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pv_q        <= pv_d;
            pidx_q      <= pidx_d;
        end
    end

    assign dut_a     = dut_a_q;
    assign busy      = run_busy;
    assign done      = (state_q == FIN);
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;

endmodule

// File: tb/tb_stim_seq_ctrl.sv
// Directed bench for stim_seq_ctrl (MAXLEN=16, LAT=1) with a one-cycle loopback DUT model.
module tb_stim_seq_ctrl;

    localparam int MAXLEN = 16;
    localparam int LAT    = 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [4:0]        len;
    logic [MAXLEN-1:0] pattern;
    logic [MAXLEN-1:0] expected;
    logic              dut_a;
    logic              dut_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [4:0]        err_cnt;
    logic [3:0]        first_err;

    int n_checks = 0;
    int n_fail   = 0;

    stim_seq_ctrl #(.MAXLEN(MAXLEN), .LAT(LAT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .len       (len),
        .pattern   (pattern),
        .expected  (expected),
        .dut_a     (dut_a),
        .dut_out   (dut_out),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_cnt   (err_cnt),
        .first_err (first_err)
    );

    // clock / reset / DUT model
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) dut_out <= dut_a;

    // Inputs are driven and outputs sampled at the falling edge (mid-cycle).
    task automatic do_run(input string name, input logic [4:0] l, input logic [15:0] pat,
                          input logic [15:0] exb, input int n_el, input logic e_pass,
                          input logic [4:0] e_err, input logic [3:0] e_first);
        @(negedge clk);
        len = l; pattern = pat; expected = exb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pattern = ~pat; expected = ~exb;
        for (int i = 0; i < n_el; i++) begin
            n_checks++;
            if (dut_a !== pat[i] || busy !== 1'b1 || done !== 1'b0) begin
                $display("FAIL %s drive[%0d]: dut_a=%b busy=%b done=%b, want dut_a=%b busy=1 done=0",
                         name, i, dut_a, busy, done, pat[i]);
                n_fail++;
            end
            @(negedge clk);
        end
        if (n_el > 0) begin
            for (int k = 0; k < LAT; k++) begin
                n_checks++;
                if (dut_a !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                    $display("FAIL %s drain[%0d]: dut_a=%b busy=%b done=%b, want 0 1 0",
                             name, k, dut_a, busy, done);
                    n_fail++;
                end
                @(negedge clk);
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || dut_a !== 1'b0) begin
            $display("FAIL %s fin: done=%b busy=%b dut_a=%b, want 1 0 0", name, done, busy, dut_a);
            n_fail++;
        end
        n_checks++;
        if (pass !== e_pass || err_cnt !== e_err || first_err !== e_first) begin
            $display("FAIL %s result: pass=%b err_cnt=%0d first_err=%0d, want %b %0d %0d",
                     name, pass, err_cnt, first_err, e_pass, e_err, e_first);
            n_fail++;
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || pass !== e_pass || err_cnt !== e_err || first_err !== e_first) begin
            $display("FAIL %s hold: done=%b pass=%b err_cnt=%0d first_err=%0d, want 0 %b %0d %0d",
                     name, done, pass, err_cnt, first_err, e_pass, e_err, e_first);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; abort = 1'b0;
        len = 5'd4; pattern = 16'h000F; expected = 16'h000F;
        repeat (3) @(negedge clk);
        n_checks++;
        if (dut_a !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 5'd0 || first_err !== 4'd0) begin
            $display("FAIL reset: dut_a=%b busy=%b done=%b pass=%b err=%0d first=%0d, want all 0",
                     dut_a, busy, done, pass, err_cnt, first_err);
            n_fail++;
        end
        start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
            n_fail++;
        end
    endtask

    task automatic test_basic();
        do_run("basic", 5'd4, 16'h000A, 16'h000A, 4, 1'b1, 5'd0, 4'd0);
    endtask

    task automatic test_mismatch();
        do_run("mismatch", 5'd4, 16'h000A, 16'h0008, 4, 1'b0, 5'd1, 4'd1);
    endtask

    task automatic test_zero_len();
        do_run("zero_len", 5'd0, 16'h00FF, 16'h0000, 0, 1'b1, 5'd0, 4'd0);
    endtask

    task automatic test_overlength();
        do_run("overlen", 5'd20, 16'hA5C3, 16'hA5F3, 16, 1'b0, 5'd2, 4'd4);
    endtask

    task automatic test_abort();
        logic [15:0] pat;
        pat = 16'h00B6;
        @(negedge clk);
        len = 5'd8; pattern = pat; expected = pat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (dut_a !== pat[i] || busy !== 1'b1) begin
                $display("FAIL abort drive[%0d]: dut_a=%b busy=%b, want %b 1", i, dut_a, busy, pat[i]);
                n_fail++;
            end
            if (i == 2) abort = 1'b1;
            else @(negedge clk);
        end
        @(negedge clk);
        abort = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dut_a !== 1'b0 || done !== 1'b0 || pass !== 1'b1 || err_cnt !== 5'd0) begin
            $display("FAIL abort_idle: busy=%b dut_a=%b done=%b pass=%b err=%0d, want 0 0 0 1 0",
                     busy, dut_a, done, pass, err_cnt);
            n_fail++;
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                $display("FAIL abort_quiet[%0d]: done=%b busy=%b, want 0 0", i, done, busy);
                n_fail++;
            end
        end
        do_run("after_abort", 5'd3, 16'h0005, 16'h0001, 3, 1'b0, 5'd1, 4'd2);
    endtask

    task automatic test_busy_start_reset();
        logic [15:0] pat;
        pat = 16'h005A;
        @(negedge clk);
        len = 5'd8; pattern = pat; expected = 16'h00FF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        len = 5'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || dut_a !== pat[2] || done !== 1'b0) begin
            $display("FAIL busy_start: busy=%b dut_a=%b done=%b, want 1 %b 0", busy, dut_a, done, pat[2]);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dut_a !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0 ||
            err_cnt !== 5'd0 || first_err !== 4'd0) begin
            $display("FAIL midrun_reset: dut_a=%b busy=%b done=%b pass=%b err=%0d first=%0d, want all 0",
                     dut_a, busy, done, pass, err_cnt, first_err);
            n_fail++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || err_cnt !== 5'd0) begin
                $display("FAIL post_reset[%0d]: done=%b busy=%b err=%0d, want 0 0 0", i, done, busy, err_cnt);
                n_fail++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        len = '0; pattern = '0; expected = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_zero_len();
        test_overlength();
        test_abort();
        test_busy_start_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stim_seq_ctrl.md
STIM_SEQ_CTRL -- requirements
Module: stim_seq_ctrl

Interface
REQ-001 SHALL have parameter MAXLEN, default 16, meaning the maximum number of stimulus elements per run.
REQ-002 SHALL have parameter LAT, default 1, range 0..3, meaning the DUT response latency in cycles from dut_a to dut_out.
REQ-003 SHALL have a single clock and a synchronous, active-low reset: clk is the clock, and rst_n is sampled only on the rising edge of clk.
REQ-004 SHALL have these ports:
  clk  input  1  clock
  rst_n  input  1  synchronous active-low reset
  start  input  1  run request
  abort  input  1  cancel the current run
  len  input  5  number of elements to run, 0..31
  pattern  input  MAXLEN  stimulus bits, element i = bit i
  expect  input  MAXLEN  expected response bits, element i = bit i
  dut_a  output  1  registered stimulus to the DUT input
  dut_out  input  1  DUT response
  busy  output  1  run in progress
  done  output  1  one-cycle completion pulse
  pass  output  1  last run had zero mismatches
  err_cnt  output  5  mismatch count of the last run
  first_err  output  4  index of the first mismatch in the last run

Function
REQ-005 SHALL implement four states: IDLE, DRIVE, DRAIN, FIN.
REQ-006 SHALL in IDLE, on start=1, latch pattern, expect and eff_len = min(len, MAXLEN), clear err_cnt and first_err, and set pass=1.
REQ-007 SHALL on that start go to FIN if eff_len=0, otherwise go to DRIVE.
REQ-008 SHALL define D as the first DRIVE cycle; in cycle D+i, for i in 0..eff_len-1, dut_a = latched pattern[i].
REQ-009 SHALL move to DRAIN after the last element when LAT>0 (DRAIN lasts LAT cycles), and directly to FIN when LAT=0.
REQ-010 SHALL compare element i using dut_out sampled at the clk edge ending cycle D+i+LAT, against latched expect[i].
REQ-011 SHALL on each mismatch increment err_cnt (saturating at 31) and clear pass.
REQ-012 SHALL record first_err only on the first mismatch of a run.
REQ-013 SHALL pulse done high for exactly one cycle, D+eff_len+LAT, in FIN, then return to IDLE; for eff_len=0, done is in the cycle after start.
REQ-014 SHALL drive busy=1 in DRIVE and DRAIN and busy=0 in IDLE and FIN.
REQ-015 SHALL drive dut_a=0 outside DRIVE.
REQ-016 SHALL ignore start when not in IDLE; pattern and expect changes mid-run have no effect.
REQ-017 SHALL on abort=1 in DRIVE or DRAIN go to IDLE on the next edge with no done pulse, dut_a=0, and err_cnt/pass/first_err holding their partial values.
REQ-018 SHALL ignore abort in IDLE and FIN; abort takes priority over start in the same cycle.
REQ-019 SHALL hold pass, err_cnt and first_err stable from FIN until the next accepted start.

Reset
REQ-020 SHALL on rst_n=0 at a clk edge set state=IDLE, dut_a=0, busy=0, done=0, pass=0, err_cnt=0, first_err=0, and clear the compare pipeline.
REQ-021 SHALL on reset mid-run discard the run, with no done pulse and no late compare after reset release.
REQ-022 SHALL ignore start while rst_n=0.

Verification
REQ-023 SHALL cover: LAT=1, len=4, pattern=4'b1010, dut_out = dut_a delayed 1 cycle, expect=4'b1010 -> dut_a = 0,1,0,1 in D..D+3, done at D+5, pass=1, err_cnt=0.
REQ-024 SHALL cover: same stimulus with expect=4'b1000 -> pass=0, err_cnt=1, first_err=1.
REQ-025 SHALL cover: len=0 -> done in the cycle after start, busy never high, pass=1, err_cnt=0.
REQ-026 SHALL cover: len=20 with MAXLEN=16 -> exactly 16 elements driven, done at D+16+LAT.
REQ-027 SHALL cover: abort at D+2 of a len=8 run -> IDLE the next cycle, no done, dut_a=0; a following start runs normally.
REQ-028 SHALL cover: start asserted while busy, and rst_n=0 at D+3 -> the busy start is ignored, the reset clears all outputs, and there is no done.
